// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone B4 pipelined bus signals for wb_cmd_master.
// Names are seen from the master side: i_* are driven toward it, o_* are driven by it.
interface wb_cmd_master_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_data;
  logic [DW/8-1:0] i_cmd_sel;

  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_rsp_timeout;

  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic          i_wb_ack;
  logic          i_wb_stall;
  logic          i_wb_err;
  logic [DW-1:0] i_wb_data;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel, i_rsp_ready,
    input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel, i_rsp_ready,
    output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_rsp_timeout,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-transaction Wishbone B4 pipelined master: one command in, one bus cycle out,
// one response back. Ends a cycle on ack, err or a cyc-high timeout.
module wb_cmd_master #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  wb_cmd_master_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_cyc, r_stb, r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [DW/8-1:0] r_sel;
  logic            r_rsp_valid, r_rsp_err, r_rsp_to;
  logic [DW-1:0]   r_rsp_data;

  logic w_busy, w_err_hit, w_ack_hit, w_tmo, w_fail;

  // r_cnt counts completed cyc-high cycles, so hitting TIMEOUT-1 marks the last allowed one
  generate
    if (TIMEOUT > 0) begin : g_tmo
      assign w_tmo = r_cyc && (r_cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_tmo
      assign w_tmo = 1'b0;
    end
  endgenerate

  // err beats ack beats timeout; ack is only meaningful once the request was accepted
  assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_err_hit = w_busy && bus.i_wb_err;
  assign w_ack_hit = (r_state == S_WAIT) && bus.i_wb_ack;
  assign w_fail    = w_err_hit || (!w_ack_hit && w_tmo);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if (r_cyc) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: if (bus.i_cmd_valid) begin
          r_we    <= bus.i_cmd_we;
          r_addr  <= bus.i_cmd_addr;
          r_data  <= bus.i_cmd_data;
          r_sel   <= bus.i_cmd_sel;
          r_cnt   <= '0;
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ, S_WAIT: begin
          if (w_fail) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_to    <= !w_err_hit;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_ack_hit) begin
            r_cyc       <= 1'b0;
            r_rsp_data  <= r_we ? '0 : bus.i_wb_data;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if ((r_state == S_REQ) && !bus.i_wb_stall) begin
            r_stb   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_RESP: if (bus.i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready   = (r_state == S_IDLE);
  assign bus.o_rsp_valid   = r_rsp_valid;
  assign bus.o_rsp_data    = r_rsp_data;
  assign bus.o_rsp_err     = r_rsp_err;
  assign bus.o_rsp_timeout = r_rsp_to;
  assign bus.o_wb_cyc      = r_cyc;
  assign bus.o_wb_stb      = r_stb;
  assign bus.o_wb_we       = r_we;
  assign bus.o_wb_addr     = r_addr;
  assign bus.o_wb_data     = r_data;
  assign bus.o_wb_sel      = r_sel;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: stimulus pushes expected responses, a negedge
// monitor pops and compares them on every response handshake.
module tb_wb_cmd_master;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();
  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response scoreboard plus the cyc/rsp_valid exclusivity rule
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_wb_cyc && bus.o_rsp_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cyc_with_rsp_valid: got cyc=1 rsp_valid=1, want never both");
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got data 0x%0h err %0b, want no response",
                   bus.o_rsp_data, bus.o_rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_data", bus.o_rsp_data, mon_e.data);
          chk("rsp_err", 32'(bus.o_rsp_err), 32'(mon_e.err));
          chk("rsp_timeout", 32'(bus.o_rsp_timeout), 32'(mon_e.to));
        end
      end
    end
  end

  // Issue one command and play the responder: stalls, then dly quiet WAIT cycles,
  // then ack/err for one cycle. Returns in the cycle the response should be valid.
  task automatic txn(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                     input logic [3:0] sel, input int stalls, input int dly,
                     input logic [31:0] rd, input logic ack, input logic err,
                     output int nstb, output logic addr_ok, output logic [31:0] wd_seen);
    nstb    = 0;
    addr_ok = 1'b1;
    wd_seen = '0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = we;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = wd;
    bus.i_cmd_sel   = sel;
    step();
    bus.i_cmd_valid = 1'b0;
    for (int j = 0; j <= stalls; j++) begin
      if (bus.o_wb_stb) nstb++;
      if (bus.o_wb_addr !== addr) addr_ok = 1'b0;
      if (j == 0) wd_seen = bus.o_wb_data;
      bus.i_wb_stall = (j < stalls);
      step();
    end
    bus.i_wb_stall = 1'b0;
    repeat (dly) step();
    bus.i_wb_ack  = ack;
    bus.i_wb_err  = err;
    bus.i_wb_data = rd;
    step();
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_err  = 1'b0;
    bus.i_wb_data = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  int          nstb, ncyc;
  logic        aok;
  logic [31:0] wds;

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_data  = '0;
    bus.i_cmd_sel   = '0;
    bus.i_rsp_ready = 1'b1;
    bus.i_wb_ack    = 1'b0;
    bus.i_wb_stall  = 1'b0;
    bus.i_wb_err    = 1'b0;
    bus.i_wb_data   = '0;

    // Reset state
    step();
    step();
    chk("rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(bus.o_wb_stb), 32'd0);
    chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.o_rsp_err), 32'd0);
    chk("rst_rsp_data", bus.o_rsp_data, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);

    // Write, no stall, ack one cycle after stb
    exp_q.push_back('{data: 32'h0, err: 1'b0, to: 1'b0});
    txn(1'b1, 30'h0, 32'h0000_A5A5, 4'hF, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, nstb, aok, wds);
    chk("wr_stb_cycles", 32'(nstb), 32'd1);
    chk("wr_wb_data", wds, 32'h0000_A5A5);
    chk("wr_cyc_low_at_rsp", 32'(bus.o_wb_cyc), 32'd0);
    chk("wr_rsp_valid_cycle3", 32'(bus.o_rsp_valid), 32'd1);
    step();
    chk("wr_rsp_valid_cleared", 32'(bus.o_rsp_valid), 32'd0);

    // Read with 3 stall cycles
    exp_q.push_back('{data: 32'h0000_1234, err: 1'b0, to: 1'b0});
    txn(1'b0, 30'h15, 32'h0, 4'hF, 3, 0, 32'h0000_1234, 1'b1, 1'b0, nstb, aok, wds);
    chk("rd_stall_stb_cycles", 32'(nstb), 32'd4);
    chk("rd_stall_addr_stable", 32'(aok), 32'd1);
    chk("rd_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();

    // Timeout: responder never answers
    exp_q.push_back('{data: 32'h0, err: 1'b1, to: 1'b1});
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = 30'h3;
    bus.i_wb_data   = 32'hBAD0_BAD0;
    step();
    bus.i_cmd_valid = 1'b0;
    ncyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.o_wb_cyc) break;
      ncyc++;
      step();
    end
    chk("tmo_cyc_cycles", 32'(ncyc), 32'd8);
    chk("tmo_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();
    bus.i_wb_ack = 1'b1;
    step();
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_data = '0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_ack_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
      chk("stray_ack_no_cyc", 32'(bus.o_wb_cyc), 32'd0);
      step();
    end
    exp_q.push_back('{data: 32'h0, err: 1'b0, to: 1'b0});
    txn(1'b1, 30'h7, 32'hDEAD_BEEF, 4'h3, 0, 1, 32'h0, 1'b1, 1'b0, nstb, aok, wds);
    chk("post_tmo_stb_cycles", 32'(nstb), 32'd1);
    chk("post_tmo_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();

    // err in WAIT, then ack and err together
    exp_q.push_back('{data: 32'h0, err: 1'b1, to: 1'b0});
    txn(1'b0, 30'h5, 32'h0, 4'hF, 0, 1, 32'hFFFF_0000, 1'b0, 1'b1, nstb, aok, wds);
    chk("err_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();
    exp_q.push_back('{data: 32'h0, err: 1'b1, to: 1'b0});
    txn(1'b0, 30'h6, 32'h0, 4'hF, 0, 0, 32'h5555_5555, 1'b1, 1'b1, nstb, aok, wds);
    chk("ackerr_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();

    // Back-pressure on the response with a second command waiting
    bus.i_rsp_ready = 1'b0;
    exp_q.push_back('{data: 32'hCAFE_0001, err: 1'b0, to: 1'b0});
    txn(1'b0, 30'h8, 32'h0, 4'hF, 0, 0, 32'hCAFE_0001, 1'b1, 1'b0, nstb, aok, wds);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = 1'b1;
    bus.i_cmd_addr  = 30'h9;
    bus.i_cmd_data  = 32'h0000_0011;
    bus.i_cmd_sel   = 4'h1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("bp_rsp_data", bus.o_rsp_data, 32'hCAFE_0001);
      chk("bp_rsp_err", 32'(bus.o_rsp_err), 32'd0);
      chk("bp_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
      step();
    end
    bus.i_rsp_ready = 1'b1;
    step();
    chk("bp_ready_after_hs", 32'(bus.o_cmd_ready), 32'd1);
    exp_q.push_back('{data: 32'h0, err: 1'b0, to: 1'b0});
    step();
    bus.i_cmd_valid = 1'b0;
    chk("bp_2nd_cyc", 32'(bus.o_wb_cyc), 32'd1);
    chk("bp_2nd_stb", 32'(bus.o_wb_stb), 32'd1);
    chk("bp_2nd_we", 32'(bus.o_wb_we), 32'd1);
    chk("bp_2nd_addr", 32'(bus.o_wb_addr), 32'h9);
    step();
    bus.i_wb_ack = 1'b1;
    step();
    bus.i_wb_ack = 1'b0;
    chk("bp_2nd_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();

    // Asynchronous reset in the middle of WAIT
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_addr  = 30'h2;
    step();
    bus.i_cmd_valid = 1'b0;
    step();
    chk("rst_pre_cyc", 32'(bus.o_wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("async_rst_stb", 32'(bus.o_wb_stb), 32'd0);
    chk("async_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    chk("post_rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    bus.i_wb_ack  = 1'b1;
    bus.i_wb_data = 32'h7777_7777;
    step();
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_data = '0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
      step();
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-transaction Wishbone B4 pipelined bus master: the initiator-side counterpart to the team's Wishbone responder peripherals (switch/LED, memory, UART). It accepts one read or write command on a valid/ready command port and issues exactly one Wishbone cycle, honoring stall. It waits for ack, err or a programmable timeout, then returns the result on a valid/ready response port. The block sits between the CPU load/store unit or debug bridge and the Wishbone interconnect.

## Interface

- AW, 30, Wishbone word-address width
- DW, 32, data width; multiple of 8
- TIMEOUT, 255, max cycles cyc may stay high before forced abort; 0 disables the timeout
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  reset; asynchronous assert, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid && ready
- i_cmd_we  in  1  1 = write, 0 = read
- i_cmd_addr  in  AW  word address
- i_cmd_data  in  DW  write data
- i_cmd_sel  in  DW/8  byte selects
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid && ready
- o_rsp_data  out  DW  read data; 0 for writes and failed transactions
- o_rsp_err  out  1  transaction failed (bus err or timeout)
- o_rsp_timeout  out  1  failure was a timeout
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone controls
- o_wb_addr  out  AW;  o_wb_data  out  DW;  o_wb_sel  out  DW/8
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each
- i_wb_data  in  DW  read data, valid with ack

## Operation

- States: IDLE, REQ, WAIT, RESP. All outputs are registered, except o_cmd_ready = (state == IDLE).
- IDLE: on i_cmd_valid, latch we/addr/data/sel into o_wb_*, clear the timeout counter, set cyc = stb = 1, go to REQ.
- REQ: cyc = stb = 1; addr/data/sel/we held stable. If !i_wb_stall, the request is accepted: stb = 0 next cycle, go to WAIT. If stalled, hold.
- WAIT: cyc = 1, stb = 0. On i_wb_ack: cyc = 0; o_rsp_data = i_wb_data for reads, 0 for writes; err = 0; go to RESP.
- i_wb_err in REQ or WAIT: cyc = stb = 0, rsp_data = 0, err = 1, timeout = 0, go to RESP.
- i_wb_ack in REQ is ignored, since no request is outstanding.
- Timeout:
  - The counter, width $clog2(TIMEOUT+1), increments every cycle cyc is high.
  - If cyc has been high TIMEOUT consecutive cycles with no ack/err, cyc and stb drop on the next edge; err = 1, timeout = 1, data = 0; go to RESP.
  - Stall cycles count toward the timeout.
- Priority on the same cycle: err > ack > timeout.
- RESP: o_rsp_valid = 1; data/err/timeout held stable until i_rsp_ready, then rsp_valid = 0 and go to IDLE. No new command is accepted in RESP.
- Ack/err while cyc is low, including late acks after an abort, is ignored.
- o_wb_addr/data/sel/we hold their last values while cyc is low.
- Reset (i_reset_n low, asynchronous, any state): state = IDLE; every output = 0 immediately, including cyc, stb, rsp_valid, rsp_data, rsp_err and rsp_timeout. o_cmd_ready becomes 1 after reset.

## Timing

- Command accepted at edge 0 → cyc/stb high in cycle 1.
- No stall: stb high exactly 1 cycle.
- With a responder that registers ack (ack in the cycle after stb accepted): ack in cycle 2, cyc low and rsp_valid high in cycle 3.
- Best-case command-to-response latency: 3 cycles. Each stall cycle adds 1, and each ack-delay cycle adds 1.
- Back-to-back: the next command can be accepted in the cycle after the response handshake. Minimum 4 cycles per transaction.
- cyc is never high while rsp_valid is high; stb is never high outside REQ.

## Test plan

- Write, no stall, ack one cycle after stb: cmd we=1 addr=0 data=0x0000_A5A5 sel=0xF → stb high exactly cycle 1 with data 0x0000_A5A5; rsp_valid in cycle 3 with err=0 and data=0.
- Read with stall high for 3 cycles, ack data 0x0000_1234 → stb high 4 cycles with addr stable; rsp_data = 0x0000_1234, err = 0.
- TIMEOUT=8, responder never acks → cyc high exactly 8 cycles, then rsp err=1, timeout=1, data=0. A later stray ack is ignored, and the next command completes normally.
- err asserted in WAIT → rsp err=1, timeout=0. In a separate run, assert ack and err in the same cycle → err=1, data=0.
- rsp_ready held low 5 cycles → rsp_valid, data and err held stable, cmd_ready=0. A second command, pending with valid high, is accepted in the cycle after the response handshake.
- i_reset_n pulled low mid-WAIT, between clock edges → cyc, stb and rsp_valid are 0 before the next edge. After release, cmd_ready=1 and an ack arriving post-reset produces no response.
